// File: rtl/pal_config_loader.sv
// pal_config_loader
// -----------------
// Loads a new select table for a PAL-style OR array, one entry per beat, into
// a shadow table. The active table (sel_flat) is replaced in one step only
// after a complete, fully legal table has been received. A table with any
// out-of-range entry is dropped and flagged on err.
//
// Parameters
//   NUM_INPUTS : number of OR-array inputs; a select value v is legal iff
//                v <= NUM_INPUTS (0 means "no term")
//   SIZE       : number of OR-array outputs = number of table entries
//   SEL_W      : width of one select entry
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   start      : begin loading a new table (honoured in IDLE only)
//   abort      : cancel an in-progress load (honoured in LOAD only)
//   wr_valid   : wr_data holds a valid entry
//   wr_data    : next entry, in index order 0..SIZE-1
//   wr_ready   : loader accepts an entry this cycle (high in LOAD only)
//   sel_flat   : active table, entry i at sel_flat[i*SEL_W +: SEL_W]
//   cfg_valid  : active table holds a committed configuration
//   busy       : high in LOAD and COMMIT
//   err        : sticky, the last load was rejected
module pal_config_loader #(
  parameter int NUM_INPUTS = 3,
  parameter int SIZE       = 4,
  parameter int SEL_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  wr_valid,
  input  logic [SEL_W-1:0]      wr_data,
  output logic                  wr_ready,
  output logic [SIZE*SEL_W-1:0] sel_flat,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int              IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
  localparam logic [31:0]     MAX_SEL  = 32'(NUM_INPUTS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic             err_pend;
  logic [SEL_W-1:0] shadow [SIZE];
  logic             illegal;

  // An entry is out of range when it names an input beyond NUM_INPUTS. The
  // compare is done at 32 bits so the parameter is never truncated.
  assign illegal = (32'(wr_data) > MAX_SEL);

  // Single-process controller. wr_ready and busy are registered alongside the
  // state so they always match it exactly. The active table is only ever
  // written in COMMIT with no pending error, so sel_flat never shows a
  // partially loaded table. An illegal entry is still stored and counted so
  // the beat count stays aligned with the sender; it just poisons the commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      index     <= '0;
      err_pend  <= 1'b0;
      sel_flat  <= '0;
      cfg_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      wr_ready  <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            index    <= '0;
            err_pend <= 1'b0;
            err      <= 1'b0;
            wr_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end

        LOAD: begin
          // abort wins over a beat offered in the same cycle
          if (abort) begin
            state    <= IDLE;
            index    <= '0;
            err_pend <= 1'b0;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
              shadow[i] <= '0;
            end
          end else if (wr_valid && wr_ready) begin
            shadow[index] <= wr_data;
            if (illegal) begin
              err_pend <= 1'b1;
            end
            // the last entry always forces COMMIT, so index never wraps
            if (index == LAST_IDX) begin
              index    <= '0;
              state    <= COMMIT;
              wr_ready <= 1'b0;
            end else begin
              index <= index + 1'b1;
            end
          end
        end

        COMMIT: begin
          if (!err_pend) begin
            for (int i = 0; i < SIZE; i++) begin
              sel_flat[i*SEL_W +: SEL_W] <= shadow[i];
            end
            cfg_valid <= 1'b1;
            err       <= 1'b0;
          end else begin
            err <= 1'b1;
          end
          err_pend <= 1'b0;
          state    <= IDLE;
          busy     <= 1'b0;
          wr_ready <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          index    <= '0;
          err_pend <= 1'b0;
          busy     <= 1'b0;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pal_config_loader.sv
// tb_pal_config_loader
// --------------------
// Self-checking bench for pal_config_loader with the default parameters
// (NUM_INPUTS=3, SIZE=4, SEL_W=3). A table of directed vectors drives one
// clock cycle per row and lists the outputs expected just after that edge;
// hand-written sequences cover the reset state and an asynchronous reset
// in the middle of a load.
module tb_pal_config_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        wr_valid;
  logic [2:0]  wr_data;
  logic        wr_ready;
  logic [11:0] sel_flat;
  logic        cfg_valid;
  logic        busy;
  logic        err;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        start;
    logic        abort;
    logic        wr_valid;
    logic [2:0]  wr_data;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_cfg;
    logic        exp_err;
    logic [11:0] exp_sel;
  } vec_t;

  vec_t vecs[$];

  pal_config_loader #(
    .NUM_INPUTS(3),
    .SIZE      (4),
    .SEL_W     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .sel_flat (sel_flat),
    .cfg_valid(cfg_valid),
    .busy     (busy),
    .err      (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares all outputs against the expected values for one step.
  task automatic checkOutput(input string tag, input logic rdy, input logic bsy,
                             input logic cfg, input logic e, input logic [11:0] sel);
    cmp({tag, ".wr_ready"},  {11'd0, wr_ready},  {11'd0, rdy});
    cmp({tag, ".busy"},      {11'd0, busy},      {11'd0, bsy});
    cmp({tag, ".cfg_valid"}, {11'd0, cfg_valid}, {11'd0, cfg});
    cmp({tag, ".err"},       {11'd0, err},       {11'd0, e});
    cmp({tag, ".sel_flat"},  sel_flat,           sel);
  endtask

  // Drives one cycle of inputs on the falling edge, then waits until just
  // after the following rising edge so the outputs can be sampled.
  task automatic applyStimulus(input logic s, input logic a, input logic v, input logic [2:0] d);
    @(negedge clk);
    start    = s;
    abort    = a;
    wr_valid = v;
    wr_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic s, input logic a, input logic v, input logic [2:0] d,
                        input logic rdy, input logic bsy, input logic cfg, input logic e,
                        input logic [11:0] sel);
    vec_t t;
    t.start     = s;
    t.abort     = a;
    t.wr_valid  = v;
    t.wr_data   = d;
    t.exp_ready = rdy;
    t.exp_busy  = bsy;
    t.exp_cfg   = cfg;
    t.exp_err   = e;
    t.exp_sel   = sel;
    vecs.push_back(t);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 3'd0;

    //      s  a  v  d     rdy bsy cfg err sel
    // basic load 1,2,3,0 -> 0x0D1 two cycles after the last beat
    addVec(1, 0, 0, 3'd0,  1, 1, 0, 0, 12'h000);
    addVec(0, 0, 1, 3'd1,  1, 1, 0, 0, 12'h000);
    addVec(0, 0, 1, 3'd2,  1, 1, 0, 0, 12'h000);
    addVec(0, 0, 1, 3'd3,  1, 1, 0, 0, 12'h000);
    addVec(0, 0, 1, 3'd0,  0, 1, 0, 0, 12'h000);
    addVec(0, 0, 0, 3'd0,  0, 0, 1, 0, 12'h0D1);
    // illegal entry 4 (first value above NUM_INPUTS): rejected, table kept
    addVec(1, 0, 0, 3'd0,  1, 1, 1, 0, 12'h0D1);
    addVec(0, 0, 1, 3'd1,  1, 1, 1, 0, 12'h0D1);
    addVec(0, 0, 1, 3'd4,  1, 1, 1, 0, 12'h0D1);
    addVec(0, 0, 1, 3'd2,  1, 1, 1, 0, 12'h0D1);
    addVec(0, 0, 1, 3'd3,  0, 1, 1, 0, 12'h0D1);
    addVec(0, 0, 0, 3'd0,  0, 0, 1, 1, 12'h0D1);
    // stray wr_valid and abort in IDLE change nothing
    addVec(0, 0, 1, 3'd7,  0, 0, 1, 1, 12'h0D1);
    addVec(0, 1, 1, 3'd5,  0, 0, 1, 1, 12'h0D1);
    // start held through LOAD and COMMIT is ignored; 3,3,2,1 -> 0x29B
    addVec(1, 0, 0, 3'd0,  1, 1, 1, 0, 12'h0D1);
    addVec(1, 0, 1, 3'd3,  1, 1, 1, 0, 12'h0D1);
    addVec(1, 0, 1, 3'd3,  1, 1, 1, 0, 12'h0D1);
    addVec(1, 0, 1, 3'd2,  1, 1, 1, 0, 12'h0D1);
    addVec(1, 0, 1, 3'd1,  0, 1, 1, 0, 12'h0D1);
    addVec(1, 0, 0, 3'd0,  0, 0, 1, 0, 12'h29B);
    // start accepted on the cycle right after COMMIT returned to IDLE
    addVec(1, 0, 0, 3'd0,  1, 1, 1, 0, 12'h29B);
    // two beats then abort together with wr_valid
    addVec(0, 0, 1, 3'd1,  1, 1, 1, 0, 12'h29B);
    addVec(0, 0, 1, 3'd2,  1, 1, 1, 0, 12'h29B);
    addVec(0, 1, 1, 3'd3,  0, 0, 1, 0, 12'h29B);
    // restarted full load 3,3,3,3 -> 0x6DB
    addVec(1, 0, 0, 3'd0,  1, 1, 1, 0, 12'h29B);
    addVec(0, 0, 1, 3'd3,  1, 1, 1, 0, 12'h29B);
    addVec(0, 0, 1, 3'd3,  1, 1, 1, 0, 12'h29B);
    addVec(0, 0, 1, 3'd3,  1, 1, 1, 0, 12'h29B);
    addVec(0, 0, 1, 3'd3,  0, 1, 1, 0, 12'h29B);
    addVec(0, 0, 0, 3'd0,  0, 0, 1, 0, 12'h6DB);
    // gaps between beats, junk data while wr_valid is low, abort in COMMIT
    addVec(1, 0, 0, 3'd0,  1, 1, 1, 0, 12'h6DB);
    addVec(0, 0, 1, 3'd1,  1, 1, 1, 0, 12'h6DB);
    addVec(0, 0, 0, 3'd0,  1, 1, 1, 0, 12'h6DB);
    addVec(0, 0, 0, 3'd5,  1, 1, 1, 0, 12'h6DB);
    addVec(0, 0, 1, 3'd2,  1, 1, 1, 0, 12'h6DB);
    addVec(0, 0, 0, 3'd7,  1, 1, 1, 0, 12'h6DB);
    addVec(0, 0, 1, 3'd3,  1, 1, 1, 0, 12'h6DB);
    addVec(0, 0, 1, 3'd0,  0, 1, 1, 0, 12'h6DB);
    addVec(0, 1, 0, 3'd0,  0, 0, 1, 0, 12'h0D1);

    // reset state while rst is held
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 0, 0, 12'h000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].wr_valid, vecs[i].wr_data);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_busy,
                  vecs[i].exp_cfg, vecs[i].exp_err, vecs[i].exp_sel);
    end

    // mid-load reset: outputs clear before the next rising edge
    applyStimulus(1, 0, 0, 3'd0);
    applyStimulus(0, 0, 1, 3'd1);
    applyStimulus(0, 0, 1, 3'd2);
    checkOutput("preRst", 1, 1, 1, 0, 12'h0D1);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("asyncRst", 0, 0, 0, 0, 12'h000);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postRst", 0, 0, 0, 0, 12'h000);

    // normal operation resumes: full load 1,2,3,0
    applyStimulus(1, 0, 0, 3'd0);
    checkOutput("resume.start", 1, 1, 0, 0, 12'h000);
    applyStimulus(0, 0, 1, 3'd1);
    applyStimulus(0, 0, 1, 3'd2);
    applyStimulus(0, 0, 1, 3'd3);
    applyStimulus(0, 0, 1, 3'd0);
    checkOutput("resume.commit", 0, 1, 0, 0, 12'h000);
    applyStimulus(0, 0, 0, 3'd0);
    checkOutput("resume.done", 0, 0, 1, 0, 12'h0D1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
